mm_engine: RTL and testbench
============================

# mm_engine

4x4 matrix-multiply engine attached to the CPU's 256-bit wide memory port (the `mm_drdata` / `mm_dwdata` / `mm_dwe` path). The CPU or glue logic streams two 256-bit operand beats (matrix A, then matrix B) into the engine. The engine computes C = A x B with one 4-term dot product per cycle and presents C as a single 256-bit beat to be written back into data memory. It sits between the dmem wide read port (upstream) and the dmem wide write port (downstream).

## Interface
Parameters:
- `EW`, 16: element width in bits, signed two's complement.
- `N`, 4: matrix dimension. Fixed; `N*N*EW` must equal 256.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  256  operand beat. Element (r,c) is at bits `[EW*(N*r+c) +: EW]`.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  engine accepts a beat this cycle.
- `out_data`  out  256  result C, same element packing as `in_data`.
- `out_valid`  out  1  `out_data` is complete and stable.
- `out_ready`  in  1  consumer takes `out_data` (drives `mm_dwe`).
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, LOAD_B, COMPUTE, DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, register `in_data` as A and go to LOAD_B.
- LOAD_B: `in_ready`=1. On handshake, register B, clear `idx` to 0, and go to COMPUTE.
- COMPUTE: `in_ready`=0. `in_valid` is ignored. Each cycle:
  - r = `idx[3:2]`, c = `idx[1:0]`.
  - C[r][c] = sum over k of A[r][k]*B[k][c].
  - Write C[r][c] into the result register at the clock edge and increment `idx`.
  - After `idx`=15 is written, go to DONE.
- DONE: `out_valid`=1. `out_data` is held stable until `out_valid && out_ready`; then go to IDLE.
- Arithmetic:
  - Products are signed 2*EW bits.
  - The 4-term sum is EW*2+2 bits with no internal overflow.
  - The stored result is the low EW bits of the sum (wrap), unless saturation is configured.
- `out_data` holds the last result after leaving DONE. It is cleared only by reset.
- Reset (asynchronous, any state, including mid-COMPUTE):
  - State goes to IDLE; `idx`, A, B, and result all go to 0.
  - Outputs: `in_ready`=0 while reset is asserted, then 1 in IDLE. `out_valid`=0, `out_data`=0, `busy`=0.

## Timing
- One beat is accepted per cycle, at the rising edge where `in_valid && in_ready`.
- A accepted at edge E allows the earliest B acceptance at edge E+1.
- B accepted at edge N: COMPUTE occupies cycles N..N+15. Element `idx`=i is written at edge N+1+i. `out_valid` rises after edge N+16, so latency is 16 cycles.
- The result handshake at edge M gives IDLE (`in_ready`=1, `out_valid`=0) after edge M. The earliest next A beat is at edge M+1.
- `out_ready` held high before DONE: completion occurs in the first DONE cycle. `out_valid` is high for exactly 1 cycle.
- No combinational path from `in_valid` or `out_ready` to any output.

## Configuration
- `MM_SATURATE_EN` defined: each stored element is clamped to [-2^(EW-1), 2^(EW-1)-1], i.e. [0x8000, 0x7FFF] for EW=16.
- Not defined: the low EW bits of the sum are stored (wrap). No clamp logic is present.

## Structure
- Package `mm_pkg`:
  - `EW`, `N` defaults.
  - `mm_state_t` enum {IDLE, LOAD_B, COMPUTE, DONE}.
  - Element-slice helper function `elem(bus, r, c)`.
- Sub-module `mm_dot4`: combinational 4-multiplier + adder tree + optional saturation. Inputs are row A[r] and column B[·][c]; output is one EW-bit element.
- Top holds the FSM, A/B/result registers, and the `idx` counter.

## Test plan
- A=identity (diagonal 0x0001), B=elements 0..15 -> C equals B; `out_valid` asserts exactly 16 cycles after the B acceptance edge.
- A=all 0x0002, B=all 0x0002 -> every C element is 0x0010. A=all 0xFFFF (-1), B=all 0xFFFF -> every element is 0x0004.
- A=all 0x7FFF, B=all 0x7FFF -> every element is 0x0004 without `MM_SATURATE_EN`, and 0x7FFF with it. A=all 0x7FFF, B=all 0x8001 -> 0xFFFC wrapped, 0x8000 saturated.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE -> `out_valid` stays 1 and `out_data` is unchanged. `in_valid`=1 with new data during COMPUTE/DONE is ignored and does not corrupt the result.
- Reset mid-op:
  - Deassert `reset` low at COMPUTE `idx`=7 -> `out_data`=0, `out_valid`=0, `busy`=0 immediately (asynchronous).
  - After release, a fresh A/B pair produces the correct result.
- Back-to-back: two A/B pairs with `out_ready`=1 and `in_valid` held high -> the second A is accepted 1 edge after the first result handshake, and both results are correct.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared definitions for the 4x4 matrix-multiply engine.
// Contents: element width / dimension defaults, FSM state type, and the
// element-slice helper used to pick A[r][c] / B[r][c] out of a 256-bit beat.
package mm_pkg;

    localparam int unsigned EW_DEF = 16;
    localparam int unsigned N_DEF  = 4;
    localparam int unsigned BUS_W  = N_DEF * N_DEF * EW_DEF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_B  = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } mm_state_t;

    // Element (r,c) of a row-major packed matrix beat.
    function automatic logic [EW_DEF-1:0] elem(input logic [BUS_W-1:0] bus,
                                               input int unsigned       r,
                                               input int unsigned       c);
        return bus[EW_DEF*(N_DEF*r + c) +: EW_DEF];
    endfunction

endpackage

// File: rtl/mm_dot4.sv
// One output element of C = A x B: N signed multiplies plus an adder tree.
// Ports:
//   a_row  in  N*EW  row A[r][0..N-1], element k at [EW*k +: EW]
//   b_col  in  N*EW  column B[0..N-1][c], element k at [EW*k +: EW]
//   dot_c  out EW    stored element (combinational)
// Build option: MM_SATURATE_EN clamps the result to the signed EW-bit range;
// without it the low EW bits of the sum are kept (wrap).
module mm_dot4
    import mm_pkg::*;
#(
    parameter int unsigned EW = EW_DEF,
    parameter int unsigned N  = N_DEF
) (
    input  logic [N*EW-1:0] a_row,
    input  logic [N*EW-1:0] b_col,
    output logic [EW-1:0]   dot_c
);

`ifdef MM_SATURATE_EN
    localparam int unsigned PW = 2 * EW;
    localparam int unsigned SW = 2 * EW + 2;
    localparam logic signed [SW-1:0] MAX_V = {{(SW-EW+1){1'b0}}, {(EW-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_V = {{(SW-EW+1){1'b1}}, {(EW-1){1'b0}}};

    logic signed [PW-1:0] prod [N];
    logic signed [SW-1:0] sum;

    // Full-precision products and sum, then clamp.
    always_comb begin
        sum = '0;
        for (int unsigned k = 0; k < N; k++) begin
            prod[k] = PW'($signed(a_row[k*EW +: EW])) * PW'($signed(b_col[k*EW +: EW]));
            sum     = sum + SW'(prod[k]);
        end
        if (sum > MAX_V) begin
            dot_c = {1'b0, {(EW-1){1'b1}}};
        end else if (sum < MIN_V) begin
            dot_c = {1'b1, {(EW-1){1'b0}}};
        end else begin
            dot_c = sum[EW-1:0];
        end
    end
`else
    logic [EW-1:0] acc;

    // The low EW bits of the full signed sum depend only on the low EW bits
    // of each product, so the wrap result is accumulated at EW bits directly.
    always_comb begin
        acc = '0;
        for (int unsigned k = 0; k < N; k++) begin
            acc = acc + EW'(a_row[k*EW +: EW] * b_col[k*EW +: EW]);
        end
        dot_c = acc;
    end
`endif

endmodule

// File: rtl/mm_engine.sv
// 4x4 signed matrix-multiply engine on the 256-bit dmem data path.
// Accepts A then B as two beats, computes one C element per cycle for 16
// cycles, then holds C on out_data until the consumer takes it.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   in_data    in   256  operand beat, element (r,c) at [EW*(N*r+c) +: EW]
//   in_valid   in   operand beat valid
//   in_ready   out  engine accepts a beat this cycle (IDLE / LOAD_B)
//   out_data   out  256  result C, same packing as in_data
//   out_valid  out  result complete and stable (DONE)
//   out_ready  in   consumer takes out_data
//   busy       out  high in any state other than IDLE
// Build option: MM_SATURATE_EN (see mm_dot4) selects clamped results.
module mm_engine
    import mm_pkg::*;
#(
    parameter int unsigned EW = EW_DEF,
    parameter int unsigned N  = N_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N*N*EW-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [N*N*EW-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam int unsigned DW = N * N * EW;

    mm_state_t     state_q, state_d;
    logic [3:0]    idx_q;
    logic [DW-1:0] a_q, b_q, c_q;
    logic          load_a, load_b, wr_en;
    logic [1:0]    row, col;
    logic [N*EW-1:0] a_row, b_col;
    logic [EW-1:0] dot;

    assign row      = idx_q[3:2];
    assign col      = idx_q[1:0];
    assign out_data = c_q;

    // Next-state and datapath strobes.
    always_comb begin
        state_d = state_q;
        load_a  = 1'b0;
        load_b  = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    load_a  = 1'b1;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (in_valid && in_ready) begin
                    load_b  = 1'b1;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                wr_en = 1'b1;
                if (idx_q == 4'd15) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; status outputs are decoded from the next state so they
    // are registered and line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == IDLE) || (state_d == LOAD_B);
            out_valid <= (state_d == DONE);
            busy      <= (state_d != IDLE);
        end
    end

    // Operand and result registers plus the element index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            idx_q <= '0;
        end else begin
            if (load_a) begin
                a_q <= in_data;
            end
            if (load_b) begin
                b_q   <= in_data;
                idx_q <= '0;
            end
            if (wr_en) begin
                c_q[EW*idx_q +: EW] <= dot;
                idx_q               <= idx_q + 4'd1;
            end
        end
    end

    // Gather row A[r][*] and column B[*][c] for the current element.
    always_comb begin
        a_row = '0;
        b_col = '0;
        for (int unsigned k = 0; k < N; k++) begin
            a_row[k*EW +: EW] = elem(a_q, 32'(row), k);
            b_col[k*EW +: EW] = elem(b_q, k, 32'(col));
        end
    end

    mm_dot4 #(
        .EW (EW),
        .N  (N)
    ) u_dot4 (
        .a_row (a_row),
        .b_col (b_col),
        .dot_c (dot)
    );

endmodule

// File: tb/tb_mm_engine.sv
// Directed bench for mm_engine: a vector table of A/B/C triples plus
// hand-written sequences for backpressure, mid-compute reset and back-to-back.
module tb_mm_engine;

    localparam int unsigned DW = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] exp_c;
    } vec_t;

    vec_t vecs [5];

    mm_engine dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk_all(input logic [15:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < 16; i++) r[i*16 +: 16] = v;
        return r;
    endfunction

    // Element i (row-major) = i * step.
    function automatic logic [DW-1:0] mk_seq(input logic [15:0] step_v);
        logic [DW-1:0] r;
        for (int i = 0; i < 16; i++) r[i*16 +: 16] = 16'(i) * step_v;
        return r;
    endfunction

    // Diagonal matrix with value v.
    function automatic logic [DW-1:0] mk_diag(input logic [15:0] v);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[(5*i)*16 +: 16] = v;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a beat and hold it until the handshake edge.
    task automatic send_beat(input logic [DW-1:0] d, input string nm);
        int n;
        n        = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: in_ready timeout got=0 expected=1", nm);
        end
        step();
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid is seen.
    task automatic wait_out(input string nm, output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        if (cyc >= 100) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: out_valid timeout got=0 expected=1", nm);
        end
    endtask

    task automatic run_vec(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] exp_c, input string nm);
        int lat;
        send_beat(a, {nm, "_a"});
        send_beat(b, {nm, "_b"});
        wait_out(nm, lat);
        chk({nm, "_latency"}, DW'(lat), DW'(16));
        chk({nm, "_data"}, out_data, exp_c);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({nm, "_valid_drop"}, DW'(out_valid), DW'(0));
        chk({nm, "_idle_ready"}, DW'(in_ready), DW'(1));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [DW-1:0] exp_sat_a, exp_sat_b;

`ifdef MM_SATURATE_EN
        exp_sat_a = mk_all(16'h7FFF);
        exp_sat_b = mk_all(16'h8000);
`else
        exp_sat_a = mk_all(16'h0004);
        exp_sat_b = mk_all(16'hFFFC);
`endif
        vecs[0] = '{a: mk_diag(16'h0001), b: mk_seq(16'h0001), exp_c: mk_seq(16'h0001)};
        vecs[1] = '{a: mk_all(16'h0002),  b: mk_all(16'h0002), exp_c: mk_all(16'h0010)};
        vecs[2] = '{a: mk_all(16'hFFFF),  b: mk_all(16'hFFFF), exp_c: mk_all(16'h0004)};
        vecs[3] = '{a: mk_all(16'h7FFF),  b: mk_all(16'h7FFF), exp_c: exp_sat_a};
        vecs[4] = '{a: mk_all(16'h7FFF),  b: mk_all(16'h8001), exp_c: exp_sat_b};

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  DW'(in_ready),  DW'(0));
        chk("rst_out_valid", DW'(out_valid), DW'(0));
        chk("rst_busy",      DW'(busy),      DW'(0));
        chk("rst_out_data",  out_data,       '0);
        reset = 1'b1;
        step();
        chk("idle_in_ready", DW'(in_ready), DW'(1));

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i].a, vecs[i].b, vecs[i].exp_c, $sformatf("vec%0d", i));
        end

        // Backpressure with junk on in_data during COMPUTE and DONE.
        send_beat(mk_all(16'h0002), "bp_a");
        send_beat(mk_all(16'h0002), "bp_b");
        in_data  = mk_all(16'h1234);
        in_valid = 1'b1;
        wait_out("bp", lat);
        chk("bp_latency", DW'(lat), DW'(16));
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp_hold_valid%0d", i), DW'(out_valid), DW'(1));
            chk($sformatf("bp_hold_data%0d", i), out_data, mk_all(16'h0010));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_valid_drop", DW'(out_valid), DW'(0));
        chk("bp_data_kept",  out_data, mk_all(16'h0010));
        chk("bp_busy_idle",  DW'(busy), DW'(0));

        // Asynchronous reset with idx at 7.
        send_beat(mk_seq(16'h0001), "rst_a");
        send_beat(mk_diag(16'h0001), "rst_b");
        repeat (7) step();
        chk("mid_busy", DW'(busy), DW'(1));
        reset = 1'b0;
        #1;
        chk("mid_rst_out_data",  out_data,       '0);
        chk("mid_rst_out_valid", DW'(out_valid), DW'(0));
        chk("mid_rst_busy",      DW'(busy),      DW'(0));
        chk("mid_rst_in_ready",  DW'(in_ready),  DW'(0));
        step();
        reset = 1'b1;
        step();
        run_vec(mk_all(16'hFFFF), mk_all(16'h0002), mk_all(16'hFFF8), "post_rst");

        // Back-to-back pairs with in_valid held high and out_ready held high.
        out_ready = 1'b1;
        in_data   = mk_all(16'h0002);
        in_valid  = 1'b1;
        step();
        in_data = mk_all(16'h0002);
        step();
        in_data = mk_diag(16'h0002);
        wait_out("b2b_1", lat);
        chk("b2b_1_latency", DW'(lat), DW'(16));
        chk("b2b_1_data", out_data, mk_all(16'h0010));
        step();
        chk("b2b_hs_valid", DW'(out_valid), DW'(0));
        chk("b2b_hs_ready", DW'(in_ready),  DW'(1));
        chk("b2b_hs_busy",  DW'(busy),      DW'(0));
        step();
        chk("b2b_a2_taken", DW'(busy), DW'(1));
        in_data = mk_seq(16'h0001);
        step();
        chk("b2b_b2_taken", DW'(in_ready), DW'(0));
        in_data = mk_all(16'h5555);
        wait_out("b2b_2", lat);
        chk("b2b_2_latency", DW'(lat), DW'(16));
        chk("b2b_2_data", out_data, mk_seq(16'h0002));
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        chk("b2b_end_busy", DW'(busy), DW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
